// File: rtl/bitmap_allocator.sv
// bitmap_allocator
//   Hands out slot indices from a WIDTH-entry bitmap and takes them back.
//   Each cycle it can grant one slot and release one slot. A grant
//   picks the lowest free slot (FIRST_PRIORITY=1) or the highest free slot
//   (FIRST_PRIORITY=0). A grant is visible in busy_map one cycle after the
//   request.
//
// Ports
//   clk             in   clock; all state changes on the rising edge
//   rst_n           in   synchronous active-low reset
//   alloc_req       in   request one slot this cycle
//   alloc_ready     out  at least one slot is free
//   alloc_index     out  slot granted when alloc_req && alloc_ready
//   free_valid      in   release free_index this cycle
//   free_index      in   slot to release (indices >= WIDTH are ignored)
//   flush           in   release every slot
//   busy_map        out  registered bitmap, 1 = allocated
//   free_count      out  registered number of free slots
//   double_free_err out  sticky flag for a release of a slot that was not held
//
// Build option
//   BITMAP_ALLOCATOR_DOUBLE_FREE_CHECK_EN : when defined, releasing a slot
//   that is already free (or out of range) sets double_free_err until
//   reset. When undefined, double_free_err is tied low.

module bitmap_allocator #(
  parameter int WIDTH          = 4,
  parameter int FIRST_PRIORITY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_req,
  output logic                       alloc_ready,
  output logic [$clog2(WIDTH)-1:0]   alloc_index,
  input  logic                       free_valid,
  input  logic [$clog2(WIDTH)-1:0]   free_index,
  input  logic                       flush,
  output logic [WIDTH-1:0]           busy_map,
  output logic [$clog2(WIDTH+1)-1:0] free_count,
  output logic                       double_free_err
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH+1);

  logic [WIDTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] free_map;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             grant;
  logic             free_in_range;
  logic             free_hit;
  logic [WIDTH-1:0] grant_mask;
  logic [WIDTH-1:0] free_mask;

  assign free_map = ~busy_q;

  // Priority pick over the free slots; first hit in scan order wins.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (FIRST_PRIORITY != 0) begin
        if (free_map[i] && !pick_found) begin
          pick_idx   = IW'(i);
          pick_found = 1'b1;
        end
      end else begin
        if (free_map[WIDTH-1-i] && !pick_found) begin
          pick_idx   = IW'(WIDTH-1-i);
          pick_found = 1'b1;
        end
      end
    end
  end

  assign alloc_ready = (count_q != '0);
  assign alloc_index = pick_idx;
  assign grant       = alloc_req && alloc_ready;

  // A release only counts when it names a slot that is actually held, so
  // the counter can never pass WIDTH and a grant/release pair never collide
  // (the granted slot is free, the released one is busy).
  assign free_in_range = (int'(free_index) < WIDTH);
  assign free_hit      = free_valid && free_in_range && busy_q[free_index];

  assign grant_mask = grant    ? (WIDTH'(1) << alloc_index) : '0;
  assign free_mask  = free_hit ? (WIDTH'(1) << free_index)  : '0;

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (flush) begin
      busy_d  = '0;
      count_d = CW'(WIDTH);
    end else begin
      busy_d  = (busy_q | grant_mask) & ~free_mask;
      count_d = count_q - CW'(grant) + CW'(free_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= CW'(WIDTH);
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_map   = busy_q;
  assign free_count = count_q;

`ifdef BITMAP_ALLOCATOR_DOUBLE_FREE_CHECK_EN
  logic err_q, err_d;

  // A flush makes any release in the same cycle meaningless, so it is not
  // treated as an error.
  assign err_d = err_q | (free_valid && !flush && !free_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign double_free_err = err_q;
`else
  assign double_free_err = 1'b0;
`endif

endmodule

// File: doc/bitmap_allocator.md
BITMAP_ALLOCATOR -- requirements
Module: bitmap_allocator

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of slots (>= 2).
REQ-002 SHALL have parameter FIRST_PRIORITY, default 1: 1 grants the lowest free index, 0 grants the highest free index.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port alloc_req  input  1  request one slot this cycle.
REQ-006 SHALL have port alloc_ready  output  1  at least one slot is free.
REQ-007 SHALL have port alloc_index  output  $clog2(WIDTH)  slot granted when alloc_req && alloc_ready.
REQ-008 SHALL have port free_valid  input  1  release one slot this cycle.
REQ-009 SHALL have port free_index  input  $clog2(WIDTH)  slot to release; its decoded one-hot bit is cleared.
REQ-010 SHALL have port flush  input  1  release all slots.
REQ-011 SHALL have port busy_map  output  WIDTH  registered bitmap; bit i = 1 means slot i is allocated.
REQ-012 SHALL have port free_count  output  $clog2(WIDTH+1)  registered count of free slots.
REQ-013 SHALL have port double_free_err  output  1  sticky error flag.

Function
REQ-014 SHALL drive alloc_ready = (free_count != 0) combinationally from registered state.
REQ-015 SHALL compute alloc_index combinationally from ~busy_map.
- FIRST_PRIORITY=1: lowest set bit of ~busy_map.
- FIRST_PRIORITY=0: highest set bit of ~busy_map.
- Value is 0 when no slot is free.
REQ-016 SHALL set busy_map[alloc_index] on the next edge when alloc_req && alloc_ready (1-cycle latency); alloc_req with alloc_ready=0 SHALL be ignored with no state change.
REQ-017 SHALL clear busy_map[free_index] on the next edge when free_valid and that bit is set.
REQ-018 SHALL compute allocation from the pre-edge busy_map, so a slot freed in cycle N is grantable no earlier than cycle N+1.
REQ-019 SHALL apply allocate and free in the same cycle together (different bits by construction); free_count then stays unchanged.
REQ-020 SHALL update free_count by the exact sum of grants and releases: -1 per grant, +1 per effective free, never below 0 nor above WIDTH.
REQ-021 SHALL, on flush, set busy_map to 0 and free_count to WIDTH on the next edge, overriding alloc and free in that cycle; alloc_ready is still evaluated from current state, but no grant takes effect.
REQ-022 SHALL treat free_valid with free_index >= WIDTH as a no-op.

Reset
REQ-023 SHALL, when rst_n=0 at a clock edge, set busy_map=0, free_count=WIDTH and double_free_err=0; rst_n has priority over flush, alloc and free.
REQ-024 SHALL, while in reset state, drive alloc_ready=1 and alloc_index=0 (FIRST_PRIORITY=1) or WIDTH-1 (FIRST_PRIORITY=0).
REQ-025 SHALL honour reset asserted mid-operation at the next edge, discarding any same-cycle request.

Configuration
REQ-026 SHALL support macro BITMAP_ALLOCATOR_DOUBLE_FREE_CHECK_EN.
- Defined: free_valid targeting a clear bit, or an index >= WIDTH, while flush=0, sets double_free_err on the next edge; it stays set until reset.
- Undefined: double_free_err is tied to 0 and such frees are silent no-ops.

Verification
REQ-027 SHALL cover: WIDTH=4, FIRST_PRIORITY=1, reset then 4 consecutive alloc_req cycles -> grants 0,1,2,3; busy_map=1111; free_count=0; alloc_ready=0.
REQ-028 SHALL cover: FIRST_PRIORITY=0 from reset, 2 allocs -> grants 3 then 2; busy_map=1100; free_count=2.
REQ-029 SHALL cover: busy_map=1111, free_valid with free_index=1 plus alloc_req in the same cycle -> no grant that cycle; next cycle alloc_index=1; busy_map=1101 then 1111.
REQ-030 SHALL cover: busy_map=0101, alloc_req plus free_index=2 in the same cycle -> busy_map=0011; free_count stays 2.
REQ-031 SHALL cover: busy_map=1011, flush plus alloc_req -> busy_map=0000; free_count=4.
REQ-032 SHALL cover: with the macro defined, free_index=2 on busy_map=0011 -> double_free_err=1 and busy_map unchanged; after rst_n=0 for 1 cycle -> double_free_err=0.
